alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
ID/EX pipeline stage sitting directly upstream of the ALU (ports Z, A, B, ALUFun, Sign). Registers decoded instruction fields from ID and resolves EX/MEM and MEM/WB forwarding. Selects shamt/immediate operands and drives the ALU's A, B, ALUFun and Sign inputs. Detects load-use hazards and inserts bubbles; honours downstream stall and branch/jump flush.

Parameters:
WIDTH, 32, datapath width
RADDR, 5, register-index width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous reset, active-low
id_valid  in  1  ID holds a real instruction
id_rs, id_rt  in  RADDR  source register indices
id_rd  in  RADDR  destination index, already resolved rd/rt/31
id_rs_data, id_rt_data  in  WIDTH  register-file read data
id_imm  in  WIDTH  extended immediate
id_shamt  in  5  shift amount
id_alu_fun  in  6  ALUFun code
id_sign  in  1  signed-compare select
id_src_a_shamt  in  1  A = zero-extended shamt
id_src_b_imm  in  1  B = immediate
id_reg_write, id_mem_read, id_mem_write  in  1  control bits
stall  in  1  downstream hold
flush  in  1  kill EX contents (branch/jump taken)
exmem_reg_write  in  1  EX/MEM forwarding enable
exmem_rd  in  RADDR  EX/MEM destination index
exmem_result  in  WIDTH  EX/MEM forwarding data
memwb_reg_write  in  1  MEM/WB forwarding enable
memwb_rd  in  RADDR  MEM/WB destination index
memwb_result  in  WIDTH  MEM/WB forwarding data
load_use_stall  out  1  tells IF/ID to hold, combinational
ex_valid  out  1  EX holds a real instruction
A, B  out  WIDTH  ALU operands
ALUFun  out  6  ALU function
Sign  out  1  ALU sign mode
ex_rd  out  RADDR  registered destination index
ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered controls, gated by ex_valid
ex_store_data  out  WIDTH  forwarded rt value for stores

Behaviour:
- Registers: valid, rs, rt, rd, rs_data, rt_data, imm, shamt, alu_fun, sign, src selects, reg_write, mem_read, mem_write.
- Reset (reset=0 at edge): all registers 0. ex_valid=0, so every gated output is 0.
- Edge priority: reset > flush > stall > load-use > load.
  - flush: valid<=0. Other fields don't-care.
  - stall (no flush): all registers hold.
  - load_use_stall (no stall/flush): valid<=0 (bubble).
  - otherwise: load all id_* fields; valid<=id_valid.
- load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt).
  - Combinational; independent of stall/flush.
  - Upstream holds ID while load_use_stall=1.
  - Asserts for exactly one cycle per hazard, then drops because the bubble clears ex_mem_read.
- Forwarding, combinational in EX, per source s in {rs, rt}:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==s: use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==s: use memwb_result.
  - Else: use the registered data.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- Operand select:
  - A = src_a_shamt ? {27'b0, shamt} : fwd_rs.
  - B = src_b_imm ? imm : fwd_rt.
  - ex_store_data = fwd_rt, independent of src_b_imm.
- Gating: when ex_valid=0, A, B, ALUFun, Sign, ex_store_data, ex_reg_write, ex_mem_read and ex_mem_write are all 0. ex_rd is still driven from its register.
- Latency: ID fields appear on ALU inputs one cycle after load. A, B, ALUFun and Sign are combinational from registers plus forwarding inputs, with no extra cycle.
- ALU codes pass through unmodified (e.g. 000000 ADD, 000001 SUB, 100000 SLL, 110011 EQ).
- Mid-operation reset discards in-flight state. The first edge with reset=1 loads normally.

Test Plan:
- Reset: hold reset=0 for 2 cycles with id_valid=1 -> ex_valid=0, A=B=0, ALUFun=0, load_use_stall=0. Release, load ADD with rs_data=10, rt_data=3 -> next cycle A=10, B=3, ALUFun=000000.
- Shift and immediate select: SLL with shamt=3, rt_data=10, src_a_shamt=1 -> A=3, B=10, ALUFun=100000. ADDI with imm=-1 -> B=32'hFFFFFFFF.
- Forwarding priority:
  - ex_rs=5, exmem_rd=5/exmem_result=7 and memwb_rd=5/memwb_result=9 -> A=7.
  - Drop exmem_reg_write -> A=9.
  - Set rs=0 with both paths matching -> A=registered data.
- Load-use: ex holds LW with rd=8; ID has rs=8, id_valid=1 -> load_use_stall=1 for one cycle. Next cycle ex_valid=0. The cycle after, the instruction loads with ex_rs=8.
- Stall vs flush: stall=1 for 3 cycles -> A, B, ALUFun unchanged. stall=1 and flush=1 together -> ex_valid=0 next cycle.
- Store data: SW with src_b_imm=1, rt=4, exmem_rd=4, exmem_result=123 -> B=imm, ex_store_data=123, ex_mem_write=1.

Source files
------------

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX register with forwarding, operand select and load-use bubble ahead of the ALU
module alu_operand_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [5:0]       id_alu_fun,
    input  logic             id_sign,
    input  logic             id_src_a_shamt,
    input  logic             id_src_b_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             stall,
    input  logic             flush,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic             load_use_stall,
    output logic             ex_valid,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [5:0]       ALUFun,
    output logic             Sign,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [WIDTH-1:0] ex_store_data
);

    logic             valid_q;
    logic [RADDR-1:0] rs_q, rt_q, rd_q;
    logic [WIDTH-1:0] rs_data_q, rt_data_q, imm_q;
    logic [4:0]       shamt_q;
    logic [5:0]       alu_fun_q;
    logic             sign_q, src_a_shamt_q, src_b_imm_q;
    logic             reg_write_q, mem_read_q, mem_write_q;
    logic [WIDTH-1:0] fwd_rs, fwd_rt;

    // A load in EX cannot forward until MEM/WB, so a dependent ID instruction waits one cycle
    assign load_use_stall = valid_q & mem_read_q & (rd_q != '0) & id_valid
                          & ((rd_q == id_rs) | (rd_q == id_rt));

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q       <= 1'b0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            alu_fun_q     <= '0;
            sign_q        <= 1'b0;
            src_a_shamt_q <= 1'b0;
            src_b_imm_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            if (load_use_stall) begin
                valid_q <= 1'b0;
            end else begin
                valid_q       <= id_valid;
                rs_q          <= id_rs;
                rt_q          <= id_rt;
                rd_q          <= id_rd;
                rs_data_q     <= id_rs_data;
                rt_data_q     <= id_rt_data;
                imm_q         <= id_imm;
                shamt_q       <= id_shamt;
                alu_fun_q     <= id_alu_fun;
                sign_q        <= id_sign;
                src_a_shamt_q <= id_src_a_shamt;
                src_b_imm_q   <= id_src_b_imm;
                reg_write_q   <= id_reg_write;
                mem_read_q    <= id_mem_read;
                mem_write_q   <= id_mem_write;
            end
        end
    end

    // Younger producer (EX/MEM) wins; register 0 is hardwired and never forwarded
    always_comb begin
        fwd_rs = rs_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q)
            fwd_rs = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q)
            fwd_rs = memwb_result;
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q)
            fwd_rt = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q)
            fwd_rt = memwb_result;
    end

    always_comb begin
        ex_valid      = valid_q;
        ex_rd         = rd_q;
        A             = '0;
        B             = '0;
        ALUFun        = '0;
        Sign          = 1'b0;
        ex_store_data = '0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        if (valid_q) begin
            A             = src_a_shamt_q ? {{(WIDTH-5){1'b0}}, shamt_q} : fwd_rs;
            B             = src_b_imm_q ? imm_q : fwd_rt;
            ALUFun        = alu_fun_q;
            Sign          = sign_q;
            ex_store_data = fwd_rt;
            ex_reg_write  = reg_write_q;
            ex_mem_read   = mem_read_q;
            ex_mem_write  = mem_write_q;
        end
    end

endmodule
